// File: rtl/change_dispense_ctrl_if.sv
// Handshake bundle between the vend FSM / hopper drivers (master) and
// change_dispense_ctrl (slave): refund request, coin requests, completion, inventory.
interface change_dispense_ctrl_if #(
    parameter int AMT_W = 4,
    parameter int INV_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             change10;
    logic             change5;
    logic             coin_ack;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain;
    logic             reload;
    logic [INV_W-1:0] reload5;
    logic [INV_W-1:0] reload10;
    logic [INV_W-1:0] inv5;
    logic [INV_W-1:0] inv10;

    modport master (
        output req_valid, req_amt, coin_ack, reload, reload5, reload10,
        input  req_ready, change10, change5, busy, done, short, remain, inv5, inv10
    );

    modport slave (
        input  req_valid, req_amt, coin_ack, reload, reload5, reload10,
        output req_ready, change10, change5, busy, done, short, remain, inv5, inv10
    );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change dispenser: 10s first, 5s as fallback on empty stock or hopper stall.
// Define CHANGE_INV_EN to enable hopper inventory tracking and reload.
module change_dispense_ctrl #(
    parameter int AMT_W      = 4,
    parameter int INV_W      = 6,
    parameter int INV5_INIT  = 20,
    parameter int INV10_INIT = 20,
    parameter int TO_CYC     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    change_dispense_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PICK   = 3'd1;
    localparam logic [2:0] WAIT10 = 3'd2;
    localparam logic [2:0] WAIT5  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state;
    logic [AMT_W-1:0] rem;
    logic             blk10;
    logic             blk5;
    logic [TO_W-1:0]  to_cnt;
    logic             have10;
    logic             have5;

`ifdef CHANGE_INV_EN
    logic [INV_W-1:0] inv5_q;
    logic [INV_W-1:0] inv10_q;

    // Reload only while idle; a coin is only debited on the ack of its own WAIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv5_q  <= INV_W'(INV5_INIT);
            inv10_q <= INV_W'(INV10_INIT);
        end else if (state == IDLE && bus.reload) begin
            inv5_q  <= bus.reload5;
            inv10_q <= bus.reload10;
        end else if (state == WAIT10 && bus.coin_ack) begin
            inv10_q <= inv10_q - INV_W'(1);
        end else if (state == WAIT5 && bus.coin_ack) begin
            inv5_q  <= inv5_q - INV_W'(1);
        end
    end

    assign have10    = (inv10_q != '0);
    assign have5     = (inv5_q != '0);
    assign bus.inv5  = inv5_q;
    assign bus.inv10 = inv10_q;
`else
    logic unused_reload;

    assign unused_reload = ^{bus.reload, bus.reload5, bus.reload10};
    assign have10        = 1'b1;
    assign have5         = 1'b1;
    assign bus.inv5      = '0;
    assign bus.inv10     = '0;
`endif

    // NOTE: every register below is written with <= so all of them update from
    // the same pre-edge values; mixing in = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            blk10  <= 1'b0;
            blk5   <= 1'b0;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rem   <= bus.req_amt;
                        blk10 <= 1'b0;
                        blk5  <= 1'b0;
                        state <= (bus.req_amt == '0) ? DONE : PICK;
                    end
                end
                PICK: begin
                    to_cnt <= '0;
                    if (rem >= AMT_W'(2) && have10 && !blk10)
                        state <= WAIT10;
                    else if (rem >= AMT_W'(1) && have5 && !blk5)
                        state <= WAIT5;
                    else
                        state <= DONE;
                end
                WAIT10: begin
                    // Ack is tested first so an ack in the last allowed cycle still counts.
                    if (bus.coin_ack) begin
                        rem   <= rem - AMT_W'(2);
                        state <= PICK;
                    end else if (to_cnt == TO_LAST) begin
                        blk10 <= 1'b1;
                        state <= PICK;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WAIT5: begin
                    if (bus.coin_ack) begin
                        rem   <= rem - AMT_W'(1);
                        state <= PICK;
                    end else if (to_cnt == TO_LAST) begin
                        blk5  <= 1'b1;
                        state <= PICK;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE: state <= IDLE;
                // NOTE: the default arm recovers from unused encodings instead of
                // leaving the state register stuck.
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.change10  = (state == WAIT10);
    assign bus.change5   = (state == WAIT5);
    assign bus.done      = (state == DONE);
    assign bus.short     = (state == DONE) && (rem != '0);
    assign bus.remain    = (state == DONE) ? rem : '0;
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl; expected values are hand-computed for
// both the CHANGE_INV_EN build and the default unlimited-inventory build.
module tb_change_dispense_ctrl;
`ifdef CHANGE_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    change_dispense_ctrl_if #(.AMT_W(4), .INV_W(6)) bus ();

    change_dispense_ctrl #(
        .AMT_W(4), .INV_W(6), .INV5_INIT(20), .INV10_INIT(20), .TO_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accepts one request, then serves hoppers until done. A 5 coin is acked in
    // its first cycle; a 10 coin is acked in WAIT cycle ack10_at (0 = never).
    task automatic run(input logic [3:0] amt, input int ack10_at, input bit do_rl,
                       input logic [5:0] rl5, input logic [5:0] rl10,
                       output int done_cyc, output int n10, output int n5,
                       output int c10, output int c5, output int bad,
                       output logic sh, output logic [3:0] rm);
        int w10;
        done_cyc = -1; n10 = 0; n5 = 0; c10 = 0; c5 = 0; bad = 0; w10 = 0;
        sh = 1'bx; rm = 'x;
        bus.req_valid = 1'b1;
        bus.req_amt   = amt;
        bus.reload    = do_rl;
        bus.reload5   = rl5;
        bus.reload10  = rl10;
        step();
        bus.req_valid = 1'b0;
        bus.reload    = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (bus.req_ready || !bus.busy) bad++;
            if (bus.done) begin
                done_cyc = cyc;
                sh = bus.short;
                rm = bus.remain;
                break;
            end
            if (bus.change10) begin
                c10++;
                w10++;
            end else begin
                w10 = 0;
            end
            if (bus.change5) c5++;
            bus.coin_ack = (bus.change10 && w10 == ack10_at) || bus.change5;
            if (bus.change10 && bus.coin_ack) n10++;
            if (bus.change5) n5++;
            step();
        end
        bus.coin_ack = 1'b0;
        step();
    endtask

    task automatic do_reload(input logic [5:0] r5, input logic [5:0] r10);
        bus.reload   = 1'b1;
        bus.reload5  = r5;
        bus.reload10 = r10;
        step();
        bus.reload   = 1'b0;
    endtask

    initial begin
        int dc, n10, n5, c10, c5, bad, dn;
        logic sh;
        logic [3:0] rm;

        bus.req_valid = 1'b0;
        bus.req_amt   = '0;
        bus.coin_ack  = 1'b0;
        bus.reload    = 1'b0;
        bus.reload5   = '0;
        bus.reload10  = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_chg10", bus.change10, 0);
        check("rst_chg5", bus.change5, 0);
        check("rst_done", bus.done, 0);
        check("rst_short", bus.short, 0);
        check("rst_remain", bus.remain, 0);
        check("rst_inv5", bus.inv5, INV_EN ? 20 : 0);
        check("rst_inv10", bus.inv10, INV_EN ? 20 : 0);

        // Greedy return of 3 steps: one 10 then one 5
        run(4'd3, 1, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("greedy_done_cyc", dc, 6);
        check("greedy_c10", c10, 1);
        check("greedy_c5", c5, 1);
        check("greedy_short", sh, 0);
        check("greedy_remain", rm, 0);
        check("greedy_busy", bad, 0);
        check("greedy_inv10", bus.inv10, INV_EN ? 19 : 0);
        check("greedy_inv5", bus.inv5, INV_EN ? 19 : 0);
        check("greedy_idle_done", bus.done, 0);
        check("greedy_idle_ready", bus.req_ready, 1);

        // Ack while idle is ignored
        bus.coin_ack = 1'b1;
        step();
        step();
        step();
        bus.coin_ack = 1'b0;
        check("idle_ack_busy", bus.busy, 0);
        check("idle_ack_inv5", bus.inv5, INV_EN ? 19 : 0);
        check("idle_ack_inv10", bus.inv10, INV_EN ? 19 : 0);

        // No 10s in stock
        do_reload(6'd5, 6'd0);
        check("rl_inv5", bus.inv5, INV_EN ? 5 : 0);
        check("rl_inv10", bus.inv10, 0);
        run(4'd4, 1, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("no10_n10", n10, INV_EN ? 0 : 2);
        check("no10_n5", n5, INV_EN ? 4 : 0);
        check("no10_done_cyc", dc, INV_EN ? 10 : 6);
        check("no10_short", sh, 0);
        check("no10_inv5", bus.inv5, INV_EN ? 1 : 0);
        check("no10_inv10", bus.inv10, 0);

        // Insufficient stock
        do_reload(6'd1, 6'd0);
        run(4'd4, 1, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("insuf_n5", n5, INV_EN ? 1 : 0);
        check("insuf_n10", n10, INV_EN ? 0 : 2);
        check("insuf_done_cyc", dc, INV_EN ? 4 : 6);
        check("insuf_short", sh, INV_EN ? 1 : 0);
        check("insuf_remain", rm, INV_EN ? 3 : 0);
        check("insuf_inv5", bus.inv5, 0);

        // 10 hopper stalls for the full timeout, 5s take over
        do_reload(6'd20, 6'd20);
        run(4'd2, 0, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("stall_c10", c10, 16);
        check("stall_n10", n10, 0);
        check("stall_n5", n5, 2);
        check("stall_done_cyc", dc, 23);
        check("stall_short", sh, 0);
        check("stall_inv10", bus.inv10, INV_EN ? 20 : 0);
        check("stall_inv5", bus.inv5, INV_EN ? 18 : 0);

        // Ack in the last allowed WAIT cycle wins over the timeout
        run(4'd2, 16, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("lastack_c10", c10, 16);
        check("lastack_n10", n10, 1);
        check("lastack_n5", n5, 0);
        check("lastack_done_cyc", dc, 19);
        check("lastack_inv10", bus.inv10, INV_EN ? 19 : 0);

        // Reload together with an accepted request
        run(4'd3, 1, 1'b1, 6'd2, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("rlreq_n10", n10, INV_EN ? 0 : 1);
        check("rlreq_n5", n5, INV_EN ? 2 : 1);
        check("rlreq_done_cyc", dc, 6);
        check("rlreq_short", sh, INV_EN ? 1 : 0);
        check("rlreq_remain", rm, INV_EN ? 1 : 0);
        check("rlreq_inv5", bus.inv5, 0);

        // Zero request
        run(4'd0, 1, 1'b0, 6'd0, 6'd0, dc, n10, n5, c10, c5, bad, sh, rm);
        check("zero_done_cyc", dc, 1);
        check("zero_coins", c10 + c5, 0);
        check("zero_short", sh, 0);
        check("zero_remain", rm, 0);

        // Reset during WAIT5 aborts the transaction
        do_reload(6'd7, 6'd7);
        bus.req_valid = 1'b1;
        bus.req_amt   = 4'd1;
        step();
        bus.req_valid = 1'b0;
        step();
        check("abort_chg5_pre", bus.change5, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_chg5", bus.change5, 0);
        check("abort_ready", bus.req_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_inv5", bus.inv5, INV_EN ? 20 : 0);
        check("abort_inv10", bus.inv10, INV_EN ? 20 : 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dn++;
            step();
        end
        check("abort_no_done", dn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
